// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing configuration block: register map,
// custom select code, preset 60 Hz timing table and FSM state encoding.
package vga_timing_pkg;

    // Register map
    localparam logic [15:0] ADDR_VGA_CONFIG    = 16'h0000;
    localparam logic [15:0] ADDR_STATUS        = 16'h0001;
    localparam logic [15:0] ADDR_SHADOW_BASE   = 16'h0008;
    localparam logic [15:0] ADDR_SHADOW_MASK   = 16'hFFF8;

    // Select code that picks the register-programmed custom timing
    localparam logic [15:0] CUSTOM_SEL_DEFAULT = 16'h00FF;

    // Shadow field offsets within the 0x08..0x0F window
    localparam logic [2:0] FLD_H_MAX   = 3'd0;
    localparam logic [2:0] FLD_V_MAX   = 3'd1;
    localparam logic [2:0] FLD_H_SYNC  = 3'd2;
    localparam logic [2:0] FLD_V_SYNC  = 3'd3;
    localparam logic [2:0] FLD_H_LEFT  = 3'd4;
    localparam logic [2:0] FLD_H_RIGHT = 3'd5;
    localparam logic [2:0] FLD_V_LEFT  = 3'd6;
    localparam logic [2:0] FLD_V_RIGHT = 3'd7;

    // Preset table: 640x480, 800x600, 1024x768, 1280x1024 at 60 Hz
    localparam logic [1:0]  PRESET_DEFAULT = 2'd0;
    localparam logic [10:0] PRESET_H_MAX   [0:3] = '{11'd799, 11'd1055, 11'd1343, 11'd1687};
    localparam logic [10:0] PRESET_V_MAX   [0:3] = '{11'd524, 11'd627,  11'd805,  11'd1065};
    localparam logic [7:0]  PRESET_H_SYNC  [0:3] = '{8'd96,   8'd128,   8'd136,   8'd112};
    localparam logic [7:0]  PRESET_V_SYNC  [0:3] = '{8'd2,    8'd4,     8'd6,     8'd3};
    localparam logic [7:0]  PRESET_H_LEFT  [0:3] = '{8'd48,   8'd88,    8'd160,   8'd248};
    localparam logic [7:0]  PRESET_H_RIGHT [0:3] = '{8'd16,   8'd40,    8'd24,    8'd48};
    localparam logic [7:0]  PRESET_V_LEFT  [0:3] = '{8'd33,   8'd23,    8'd29,    8'd38};
    localparam logic [7:0]  PRESET_V_RIGHT [0:3] = '{8'd10,   8'd1,     8'd3,     8'd1};

    // Configuration FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2,
        ST_SETTLE  = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/vga_timing_cfg_if.sv
// Configuration write bus: single-cycle write strobe with a ready handshake.
interface vga_timing_cfg_if #(
    parameter int CONFIG_WIDTH = 16
);
    logic                    Valid;
    logic [CONFIG_WIDTH-1:0] Addr;
    logic [CONFIG_WIDTH-1:0] Data;
    logic                    Ready;

    modport master (output Valid, output Addr, output Data, input Ready);
    modport slave  (input Valid, input Addr, input Data, output Ready);
endinterface

// File: rtl/vga_cfg_preset_rom.sv
// Combinational preset lookup: select code to the eight timing fields.
// Codes outside the populated table report Sel_valid low and return preset 0.
module vga_cfg_preset_rom
    import vga_timing_pkg::*;
#(
    parameter int CONFIG_WIDTH  = 16,
    parameter int NUM_PRESETS   = 4,
    parameter int PULSE_WIDTH   = 8,
    parameter int REZ_MAX_WIDTH = 11,
    parameter int MARGIN_WIDTH  = 8
) (
    input  logic [CONFIG_WIDTH-1:0]  Sel,
    output logic                     Sel_valid,
    output logic [REZ_MAX_WIDTH-1:0] H_count_max,
    output logic [REZ_MAX_WIDTH-1:0] V_count_max,
    output logic [PULSE_WIDTH-1:0]   H_sync_pulse,
    output logic [PULSE_WIDTH-1:0]   V_sync_pulse,
    output logic [MARGIN_WIDTH-1:0]  H_left_margin,
    output logic [MARGIN_WIDTH-1:0]  H_right_margin,
    output logic [MARGIN_WIDTH-1:0]  V_left_margin,
    output logic [MARGIN_WIDTH-1:0]  V_right_margin
);

    logic [1:0] idx_s;

    // Range-check the select code and read the matching table row
    always_comb begin
        idx_s     = PRESET_DEFAULT;
        Sel_valid = 1'b0;
        if (Sel < CONFIG_WIDTH'(NUM_PRESETS)) begin
            idx_s     = Sel[1:0];
            Sel_valid = 1'b1;
        end else begin
            idx_s     = PRESET_DEFAULT;
            Sel_valid = 1'b0;
        end
        H_count_max    = REZ_MAX_WIDTH'(PRESET_H_MAX[idx_s]);
        V_count_max    = REZ_MAX_WIDTH'(PRESET_V_MAX[idx_s]);
        H_sync_pulse   = PULSE_WIDTH'(PRESET_H_SYNC[idx_s]);
        V_sync_pulse   = PULSE_WIDTH'(PRESET_V_SYNC[idx_s]);
        H_left_margin  = MARGIN_WIDTH'(PRESET_H_LEFT[idx_s]);
        H_right_margin = MARGIN_WIDTH'(PRESET_H_RIGHT[idx_s]);
        V_left_margin  = MARGIN_WIDTH'(PRESET_V_LEFT[idx_s]);
        V_right_margin = MARGIN_WIDTH'(PRESET_V_RIGHT[idx_s]);
    end

endmodule

// File: rtl/vga_timing_cfg.sv
// VGA timing configuration: preset table plus programmable custom timing.
// Requests are validated when written and applied only on a frame boundary
// (or immediately while the counters are stopped), followed by a settle
// window during which the bus is held off.
module vga_timing_cfg
    import vga_timing_pkg::*;
#(
    parameter int                    CONFIG_WIDTH  = 16,
    parameter int                    NUM_PRESETS   = 4,
    parameter int                    PULSE_WIDTH   = 8,
    parameter int                    REZ_MAX_WIDTH = 11,
    parameter int                    MARGIN_WIDTH  = 8,
    parameter int                    SETTLE_CYCLES = 4,
    parameter logic [CONFIG_WIDTH-1:0] CUSTOM_SEL  = CONFIG_WIDTH'(CUSTOM_SEL_DEFAULT)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    vga_timing_cfg_if.slave          bus,
    input  logic                     Frame_end,
    input  logic                     Timing_en,
    output logic                     Load_config,
    output logic                     Cfg_err,
    output logic [CONFIG_WIDTH-1:0]  Active_sel,
    output logic [PULSE_WIDTH-1:0]   H_sync_pulse,
    output logic [PULSE_WIDTH-1:0]   V_sync_pulse,
    output logic [REZ_MAX_WIDTH-1:0] H_count_max,
    output logic [REZ_MAX_WIDTH-1:0] V_count_max,
    output logic [MARGIN_WIDTH-1:0]  H_left_margin,
    output logic [MARGIN_WIDTH-1:0]  H_right_margin,
    output logic [MARGIN_WIDTH-1:0]  V_left_margin,
    output logic [MARGIN_WIDTH-1:0]  V_right_margin
);

    // Porch/sync sum is widened so even all-ones fields cannot wrap
    localparam int SUM_W = REZ_MAX_WIDTH + 32'sd2;
    localparam int CNT_W = (SETTLE_CYCLES > 32'sd1) ? $clog2(SETTLE_CYCLES) : 32'sd1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 32'sd1);

    // True when sync + both porches + 1 fits inside the total count
    function automatic logic timing_fits(
        input logic [PULSE_WIDTH-1:0]   sync,
        input logic [MARGIN_WIDTH-1:0]  left,
        input logic [MARGIN_WIDTH-1:0]  right,
        input logic [REZ_MAX_WIDTH-1:0] cmax
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(sync) + SUM_W'(left) + SUM_W'(right) + SUM_W'(1'b1);
        return (sum <= SUM_W'(cmax));
    endfunction

    cfg_state_e              state_r;
    logic                    ready_r;
    logic                    load_r;
    logic                    cfg_err_r;
    logic [CNT_W-1:0]        settle_cnt_r;

    // Custom shadow fields (bus-written)
    logic [REZ_MAX_WIDTH-1:0] sh_h_max_r,  sh_v_max_r;
    logic [PULSE_WIDTH-1:0]   sh_h_sync_r, sh_v_sync_r;
    logic [MARGIN_WIDTH-1:0]  sh_h_left_r, sh_h_right_r, sh_v_left_r, sh_v_right_r;

    // Pending fields (captured at select time)
    logic [CONFIG_WIDTH-1:0]  pd_sel_r;
    logic [REZ_MAX_WIDTH-1:0] pd_h_max_r,  pd_v_max_r;
    logic [PULSE_WIDTH-1:0]   pd_h_sync_r, pd_v_sync_r;
    logic [MARGIN_WIDTH-1:0]  pd_h_left_r, pd_h_right_r, pd_v_left_r, pd_v_right_r;

    // Active fields (drive the counters)
    logic [CONFIG_WIDTH-1:0]  act_sel_r;
    logic [REZ_MAX_WIDTH-1:0] act_h_max_r,  act_v_max_r;
    logic [PULSE_WIDTH-1:0]   act_h_sync_r, act_v_sync_r;
    logic [MARGIN_WIDTH-1:0]  act_h_left_r, act_h_right_r, act_v_left_r, act_v_right_r;

    // Preset lookup results
    logic                     rom_valid_s;
    logic [REZ_MAX_WIDTH-1:0] rom_h_max_s,  rom_v_max_s;
    logic [PULSE_WIDTH-1:0]   rom_h_sync_s, rom_v_sync_s;
    logic [MARGIN_WIDTH-1:0]  rom_h_left_s, rom_h_right_s, rom_v_left_s, rom_v_right_s;

    // Candidate configuration for the code currently on the data bus
    logic                     cand_valid_s;
    logic [REZ_MAX_WIDTH-1:0] cand_h_max_s,  cand_v_max_s;
    logic [PULSE_WIDTH-1:0]   cand_h_sync_s, cand_v_sync_s;
    logic [MARGIN_WIDTH-1:0]  cand_h_left_s, cand_h_right_s, cand_v_left_s, cand_v_right_s;

    logic wr_s;
    logic is_cfg_s;
    logic is_status_s;
    logic is_shadow_s;
    logic custom_ok_s;

    assign wr_s        = bus.Valid & ready_r;
    assign is_cfg_s    = (bus.Addr == CONFIG_WIDTH'(ADDR_VGA_CONFIG));
    assign is_status_s = (bus.Addr == CONFIG_WIDTH'(ADDR_STATUS));
    assign is_shadow_s = ((bus.Addr & CONFIG_WIDTH'(ADDR_SHADOW_MASK)) == CONFIG_WIDTH'(ADDR_SHADOW_BASE));
    assign custom_ok_s = timing_fits(sh_h_sync_r, sh_h_left_r, sh_h_right_r, sh_h_max_r) &
                         timing_fits(sh_v_sync_r, sh_v_left_r, sh_v_right_r, sh_v_max_r);

    vga_cfg_preset_rom #(
        .CONFIG_WIDTH  (CONFIG_WIDTH),
        .NUM_PRESETS   (NUM_PRESETS),
        .PULSE_WIDTH   (PULSE_WIDTH),
        .REZ_MAX_WIDTH (REZ_MAX_WIDTH),
        .MARGIN_WIDTH  (MARGIN_WIDTH)
    ) u_preset_rom (
        .Sel            (bus.Data),
        .Sel_valid      (rom_valid_s),
        .H_count_max    (rom_h_max_s),
        .V_count_max    (rom_v_max_s),
        .H_sync_pulse   (rom_h_sync_s),
        .V_sync_pulse   (rom_v_sync_s),
        .H_left_margin  (rom_h_left_s),
        .H_right_margin (rom_h_right_s),
        .V_left_margin  (rom_v_left_s),
        .V_right_margin (rom_v_right_s)
    );

    // Pick preset or custom fields for the requested code and judge validity
    always_comb begin
        cand_valid_s   = 1'b0;
        cand_h_max_s   = rom_h_max_s;
        cand_v_max_s   = rom_v_max_s;
        cand_h_sync_s  = rom_h_sync_s;
        cand_v_sync_s  = rom_v_sync_s;
        cand_h_left_s  = rom_h_left_s;
        cand_h_right_s = rom_h_right_s;
        cand_v_left_s  = rom_v_left_s;
        cand_v_right_s = rom_v_right_s;
        if (rom_valid_s) begin
            cand_valid_s = 1'b1;
        end else if (bus.Data == CUSTOM_SEL) begin
            cand_valid_s   = custom_ok_s;
            cand_h_max_s   = sh_h_max_r;
            cand_v_max_s   = sh_v_max_r;
            cand_h_sync_s  = sh_h_sync_r;
            cand_v_sync_s  = sh_v_sync_r;
            cand_h_left_s  = sh_h_left_r;
            cand_h_right_s = sh_h_right_r;
            cand_v_left_s  = sh_v_left_r;
            cand_v_right_s = sh_v_right_r;
        end else begin
            cand_valid_s = 1'b0;
        end
    end

    // Custom shadow registers, written through the 0x08..0x0F window
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sh_h_max_r   <= REZ_MAX_WIDTH'(PRESET_H_MAX[PRESET_DEFAULT]);
            sh_v_max_r   <= REZ_MAX_WIDTH'(PRESET_V_MAX[PRESET_DEFAULT]);
            sh_h_sync_r  <= PULSE_WIDTH'(PRESET_H_SYNC[PRESET_DEFAULT]);
            sh_v_sync_r  <= PULSE_WIDTH'(PRESET_V_SYNC[PRESET_DEFAULT]);
            sh_h_left_r  <= MARGIN_WIDTH'(PRESET_H_LEFT[PRESET_DEFAULT]);
            sh_h_right_r <= MARGIN_WIDTH'(PRESET_H_RIGHT[PRESET_DEFAULT]);
            sh_v_left_r  <= MARGIN_WIDTH'(PRESET_V_LEFT[PRESET_DEFAULT]);
            sh_v_right_r <= MARGIN_WIDTH'(PRESET_V_RIGHT[PRESET_DEFAULT]);
        end else if (wr_s && is_shadow_s) begin
            case (bus.Addr[2:0])
                FLD_H_MAX:   sh_h_max_r   <= bus.Data[REZ_MAX_WIDTH-1:0];
                FLD_V_MAX:   sh_v_max_r   <= bus.Data[REZ_MAX_WIDTH-1:0];
                FLD_H_SYNC:  sh_h_sync_r  <= bus.Data[PULSE_WIDTH-1:0];
                FLD_V_SYNC:  sh_v_sync_r  <= bus.Data[PULSE_WIDTH-1:0];
                FLD_H_LEFT:  sh_h_left_r  <= bus.Data[MARGIN_WIDTH-1:0];
                FLD_H_RIGHT: sh_h_right_r <= bus.Data[MARGIN_WIDTH-1:0];
                FLD_V_LEFT:  sh_v_left_r  <= bus.Data[MARGIN_WIDTH-1:0];
                FLD_V_RIGHT: sh_v_right_r <= bus.Data[MARGIN_WIDTH-1:0];
                default:     sh_h_max_r   <= sh_h_max_r;
            endcase
        end else begin
            sh_h_max_r <= sh_h_max_r;
        end
    end

    // Configuration FSM: accept/validate, wait for frame boundary, apply, settle
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r       <= ST_APPLY;
            ready_r       <= 1'b0;
            load_r        <= 1'b1;
            cfg_err_r     <= 1'b0;
            settle_cnt_r  <= '0;
            pd_sel_r      <= '0;
            pd_h_max_r    <= REZ_MAX_WIDTH'(PRESET_H_MAX[PRESET_DEFAULT]);
            pd_v_max_r    <= REZ_MAX_WIDTH'(PRESET_V_MAX[PRESET_DEFAULT]);
            pd_h_sync_r   <= PULSE_WIDTH'(PRESET_H_SYNC[PRESET_DEFAULT]);
            pd_v_sync_r   <= PULSE_WIDTH'(PRESET_V_SYNC[PRESET_DEFAULT]);
            pd_h_left_r   <= MARGIN_WIDTH'(PRESET_H_LEFT[PRESET_DEFAULT]);
            pd_h_right_r  <= MARGIN_WIDTH'(PRESET_H_RIGHT[PRESET_DEFAULT]);
            pd_v_left_r   <= MARGIN_WIDTH'(PRESET_V_LEFT[PRESET_DEFAULT]);
            pd_v_right_r  <= MARGIN_WIDTH'(PRESET_V_RIGHT[PRESET_DEFAULT]);
            act_sel_r     <= '0;
            act_h_max_r   <= REZ_MAX_WIDTH'(PRESET_H_MAX[PRESET_DEFAULT]);
            act_v_max_r   <= REZ_MAX_WIDTH'(PRESET_V_MAX[PRESET_DEFAULT]);
            act_h_sync_r  <= PULSE_WIDTH'(PRESET_H_SYNC[PRESET_DEFAULT]);
            act_v_sync_r  <= PULSE_WIDTH'(PRESET_V_SYNC[PRESET_DEFAULT]);
            act_h_left_r  <= MARGIN_WIDTH'(PRESET_H_LEFT[PRESET_DEFAULT]);
            act_h_right_r <= MARGIN_WIDTH'(PRESET_H_RIGHT[PRESET_DEFAULT]);
            act_v_left_r  <= MARGIN_WIDTH'(PRESET_V_LEFT[PRESET_DEFAULT]);
            act_v_right_r <= MARGIN_WIDTH'(PRESET_V_RIGHT[PRESET_DEFAULT]);
        end else begin
            load_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (wr_s && is_cfg_s) begin
                        if (cand_valid_s) begin
                            pd_sel_r     <= bus.Data;
                            pd_h_max_r   <= cand_h_max_s;
                            pd_v_max_r   <= cand_v_max_s;
                            pd_h_sync_r  <= cand_h_sync_s;
                            pd_v_sync_r  <= cand_v_sync_s;
                            pd_h_left_r  <= cand_h_left_s;
                            pd_h_right_r <= cand_h_right_s;
                            pd_v_left_r  <= cand_v_left_s;
                            pd_v_right_r <= cand_v_right_s;
                            state_r      <= ST_PENDING;
                            ready_r      <= 1'b0;
                        end else begin
                            cfg_err_r <= 1'b1;
                        end
                    end else if (wr_s && is_status_s) begin
                        cfg_err_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PENDING: begin
                    // Active fields switch on the edge entering APPLY
                    if (Frame_end || !Timing_en) begin
                        act_sel_r     <= pd_sel_r;
                        act_h_max_r   <= pd_h_max_r;
                        act_v_max_r   <= pd_v_max_r;
                        act_h_sync_r  <= pd_h_sync_r;
                        act_v_sync_r  <= pd_v_sync_r;
                        act_h_left_r  <= pd_h_left_r;
                        act_h_right_r <= pd_h_right_r;
                        act_v_left_r  <= pd_v_left_r;
                        act_v_right_r <= pd_v_right_r;
                        load_r        <= 1'b1;
                        state_r       <= ST_APPLY;
                    end else begin
                        state_r <= ST_PENDING;
                    end
                end
                ST_APPLY: begin
                    settle_cnt_r <= '0;
                    state_r      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + CNT_W'(1'b1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Ready      = ready_r;
    assign Load_config    = load_r;
    assign Cfg_err        = cfg_err_r;
    assign Active_sel     = act_sel_r;
    assign H_count_max    = act_h_max_r;
    assign V_count_max    = act_v_max_r;
    assign H_sync_pulse   = act_h_sync_r;
    assign V_sync_pulse   = act_v_sync_r;
    assign H_left_margin  = act_h_left_r;
    assign H_right_margin = act_h_right_r;
    assign V_left_margin  = act_v_left_r;
    assign V_right_margin = act_v_right_r;

endmodule
